text_console: RTL and testbench

- Upstream feeder of the character renderer. Accepts a stream of ASCII bytes over a valid/ready handshake.
- Maintains a text cursor and writes characters into the video RAM text window at VIDEO_RAM + row*TEXTCOL + col. This is the window the renderer scans at 64x37 cells.
- Handles control codes, line wrap, hardware scroll (row copy) and screen clear. The CPU can print without computing addresses.

---
 rtl/text_console.sv | 215 +++++++++++++++++++++
 tb/tb_text_console.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_console.sv
// Character-stream front end for the text renderer: places bytes at the cursor
// in video RAM and handles CR/LF/BS/FF, line wrap, row-copy scrolling and clear.
// Handshakes: a byte transfers on a cycle with in_valid & in_ready; a memory access
// completes on a cycle with (mem_we | mem_re) & mem_gnt, with all request outputs held until then.
module text_console #(
    parameter int          ADDRW     = 15,
    parameter int          VIDEO_RAM = 'h1000,
    parameter int          TEXTCOL   = 64,
    parameter int          TEXTROW   = 37,
    parameter logic [7:0]  BLANK     = 8'h20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             clear,
    output logic [ADDRW-1:0] mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic             mem_gnt,
    input  logic [7:0]       mem_rdata,
    output logic [5:0]       cursor_col,
    output logic [5:0]       cursor_row,
    output logic             busy
);

    localparam int CW    = $clog2(TEXTCOL);
    localparam int CELLS = TEXTROW * TEXTCOL;
    localparam int IW    = $clog2(CELLS);

    localparam logic [ADDRW-1:0] BASE        = ADDRW'(VIDEO_RAM);
    localparam logic [IW-1:0]    LAST_CELL   = IW'(CELLS - 1);
    localparam logic [IW-1:0]    LAST_KEEP   = IW'((TEXTROW - 1) * TEXTCOL - 1);
    localparam logic [IW-1:0]    FIRST_BLANK = IW'((TEXTROW - 1) * TEXTCOL);
    localparam logic [5:0]       LAST_COL    = 6'(TEXTCOL - 1);
    localparam logic [5:0]       LAST_ROW    = 6'(TEXTROW - 1);

    typedef enum logic [2:0] {
        IDLE, DECODE, PUT, SCROLL_RD, SCROLL_WR, SCROLL_BLANK, CLEAR
    } state_t;

    state_t          state, state_n;
    logic [5:0]      col, col_n, row, row_n;
    logic [IW-1:0]   idx, idx_n;
    logic [7:0]      ch, ch_n, hold, hold_n;
    logic            adv, adv_n, first, first_n;

    logic            we_c, re_c, ready_c;
    logic [ADDRW-1:0] addr_c, cell_addr, idx_addr;
    logic [7:0]      wdata_c;

    // row*TEXTCOL is a plain shift because TEXTCOL is a power of two
    assign cell_addr = BASE + (ADDRW'(row) << CW) + ADDRW'(col);
    assign idx_addr  = BASE + ADDRW'(idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            col   <= '0;
            row   <= '0;
            idx   <= '0;
            ch    <= '0;
            hold  <= '0;
            adv   <= 1'b0;
            first <= 1'b0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            idx   <= idx_n;
            ch    <= ch_n;
            hold  <= hold_n;
            adv   <= adv_n;
            first <= first_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        idx_n   = idx;
        ch_n    = ch;
        hold_n  = hold;
        adv_n   = adv;
        first_n = 1'b0;
        we_c    = 1'b0;
        re_c    = 1'b0;
        ready_c = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state)
            IDLE: begin
                ready_c = ~clear;
                if (clear) begin
                    state_n = CLEAR;
                    idx_n   = '0;
                end else if (in_valid) begin
                    ch_n    = in_data;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                state_n = IDLE;
                if (ch >= 8'h20 && ch <= 8'h7E) begin
                    adv_n   = 1'b1;
                    state_n = PUT;
                end else begin
                    case (ch)
                        8'h0D: col_n = '0;
                        8'h0A: begin
                            col_n = '0;
                            if (row < LAST_ROW) begin
                                row_n = row + 6'd1;
                            end else begin
                                idx_n   = '0;
                                state_n = SCROLL_RD;
                            end
                        end
                        8'h08: begin
                            // backspace blanks the cell left of the cursor and parks there
                            if (col != 6'd0) begin
                                col_n   = col - 6'd1;
                                ch_n    = BLANK;
                                adv_n   = 1'b0;
                                state_n = PUT;
                            end
                        end
                        8'h0C: begin
                            idx_n   = '0;
                            state_n = CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            PUT: begin
                we_c    = 1'b1;
                addr_c  = cell_addr;
                wdata_c = ch;
                if (mem_gnt) begin
                    state_n = IDLE;
                    if (adv) begin
                        if (col == LAST_COL) begin
                            col_n = '0;
                            if (row < LAST_ROW) begin
                                row_n = row + 6'd1;
                            end else begin
                                idx_n   = '0;
                                state_n = SCROLL_RD;
                            end
                        end else begin
                            col_n = col + 6'd1;
                        end
                    end
                end
            end
            SCROLL_RD: begin
                re_c   = 1'b1;
                addr_c = idx_addr + ADDRW'(TEXTCOL);
                if (mem_gnt) begin
                    first_n = 1'b1;
                    state_n = SCROLL_WR;
                end
            end
            SCROLL_WR: begin
                // read data is only valid on the first cycle; keep a copy for stalled grants
                we_c    = 1'b1;
                addr_c  = idx_addr;
                wdata_c = first ? mem_rdata : hold;
                hold_n  = wdata_c;
                if (mem_gnt) begin
                    if (idx < LAST_KEEP) begin
                        idx_n   = idx + 1'b1;
                        state_n = SCROLL_RD;
                    end else begin
                        idx_n   = FIRST_BLANK;
                        state_n = SCROLL_BLANK;
                    end
                end
            end
            SCROLL_BLANK, CLEAR: begin
                we_c    = 1'b1;
                addr_c  = idx_addr;
                wdata_c = BLANK;
                if (mem_gnt) begin
                    if (idx == LAST_CELL) begin
                        idx_n   = '0;
                        state_n = IDLE;
                        if (state == CLEAR) begin
                            col_n = '0;
                            row_n = '0;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    // requests are suppressed while reset is held even though state already reads CLEAR
    assign mem_we     = we_c & rst_n;
    assign mem_re     = re_c & rst_n;
    assign in_ready   = ready_c & rst_n;
    assign mem_addr   = addr_c;
    assign mem_wdata  = wdata_c;
    assign busy       = (state != IDLE);
    assign cursor_col = col;
    assign cursor_row = row;

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: behavioural video RAM, vector table,
// hand-written corner sequences and a random byte stream against a screen model.
module tb_text_console;

    localparam int COLS  = 64;
    localparam int ROWS  = 37;
    localparam int CELLS = COLS * ROWS;
    localparam int KEEP  = CELLS - COLS;
    localparam int BASE  = 'h1000;

    typedef struct {
        logic        wr;
        logic [14:0] addr;
        logic [7:0]  data;
    } acc_t;

    typedef struct {
        logic [7:0]  ch;
        int          nwr;
        logic [14:0] addr;
        logic [7:0]  data;
        int          col;
        int          row;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        clear = 1'b0;
    logic        mem_gnt = 1'b1;
    logic [7:0]  mem_rdata = 8'h00;
    logic        in_ready, mem_we, mem_re, busy;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [5:0]  cursor_col, cursor_row;

    text_console dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clear(clear), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         fails = 0;
    bit         gnt_rand = 1'b0;
    logic [7:0] ram [CELLS];
    acc_t       log_q [$];
    logic       pend = 1'b0;
    logic [24:0] p_vec;
    logic [7:0] scr [CELLS];
    int         mcol, mrow;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // grant changes just after the active edge
    always @(posedge clk) begin
        #1;
        mem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // video RAM, access log and bus protocol monitor, all sampled on the falling edge
    always @(negedge clk) begin : mem_model
        int off;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            off = int'(mem_addr) - BASE;
            if (mem_we | mem_re) begin
                chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
                chk("addr_in_window", 32'(off >= 0 && off < CELLS), 32'd1);
            end
            if (!busy) chk("idle_no_access", 32'(mem_we | mem_re), 32'd0);
            if (pend) chk("held_while_ungranted", 32'({mem_we, mem_re, mem_addr, mem_wdata}), 32'(p_vec));
            if ((mem_we | mem_re) && mem_gnt && off >= 0 && off < CELLS) begin
                if (mem_we) begin
                    ram[off] = mem_wdata;
                    log_q.push_back('{1'b1, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = ram[off];
                    log_q.push_back('{1'b0, mem_addr, ram[off]});
                end
            end
            pend  = (mem_we | mem_re) & ~mem_gnt;
            p_vec = {mem_we, mem_re, mem_addr, mem_wdata};
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // called just after a rising edge; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 20000) begin
                checks++;
                fails++;
                $display("FAIL send_byte: in_ready still 0 after %0d cycles, required 1", n);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (cyc > 20000) begin
                checks++;
                fails++;
                $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_clear(input string nm);
        int bad = 0;
        chk({nm, "_count"}, 32'(log_q.size()), 32'(CELLS));
        for (int k = 0; k < log_q.size() && k < CELLS; k++)
            if (!log_q[k].wr || log_q[k].addr != 15'(BASE + k) || log_q[k].data != 8'h20) bad++;
        chk({nm, "_order"}, 32'(bad), 32'd0);
    endtask

    // screen model: cursor rules applied to a 2-D character grid
    task automatic model_newline();
        if (mrow < ROWS - 1) begin
            mrow++;
        end else begin
            for (int i = 0; i < KEEP; i++) scr[i] = scr[i + COLS];
            for (int i = KEEP; i < CELLS; i++) scr[i] = 8'h20;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mrow * COLS + mcol] = b;
            if (mcol == COLS - 1) begin
                mcol = 0;
                model_newline();
            end else begin
                mcol++;
            end
        end else if (b == 8'h0D) begin
            mcol = 0;
        end else if (b == 8'h0A) begin
            mcol = 0;
            model_newline();
        end else if (b == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                scr[mrow * COLS + mcol] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
            mcol = 0;
            mrow = 0;
        end
    endtask

    task automatic drive(input logic [7:0] b);
        int c;
        model_byte(b);
        send_byte(b);
        wait_idle(c);
        chk("rand_col", 32'(cursor_col), 32'(mcol));
        chk("rand_row", 32'(cursor_row), 32'(mrow));
    endtask

    initial begin
        vec_t vt [$];
        int   c, bad, r;
        logic [7:0] b;

        vt.push_back('{8'h48, 1, 15'h1000, 8'h48, 1, 0});
        vt.push_back('{8'h69, 1, 15'h1001, 8'h69, 2, 0});
        vt.push_back('{8'h08, 1, 15'h1001, 8'h20, 1, 0});
        vt.push_back('{8'h08, 1, 15'h1000, 8'h20, 0, 0});
        vt.push_back('{8'h08, 0, 15'h0000, 8'h00, 0, 0});
        vt.push_back('{8'h7E, 1, 15'h1000, 8'h7E, 1, 0});
        vt.push_back('{8'h0D, 0, 15'h0000, 8'h00, 0, 0});
        vt.push_back('{8'h0A, 0, 15'h0000, 8'h00, 0, 1});
        vt.push_back('{8'h7F, 0, 15'h0000, 8'h00, 0, 1});
        vt.push_back('{8'h1F, 0, 15'h0000, 8'h00, 0, 1});
        vt.push_back('{8'h20, 1, 15'h1040, 8'h20, 1, 1});
        vt.push_back('{8'h5A, 1, 15'h1041, 8'h5A, 2, 1});
        vt.push_back('{8'h0C, CELLS, 15'h1000, 8'h20, 0, 0});

        // reset values and power-up clear
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_we_re", 32'({mem_we, mem_re}), 32'd0);
        chk("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        log_q.delete();
        rst_n = 1'b1;
        wait_idle(c);
        chk("reset_clear_cycles", 32'(c), 32'(CELLS));
        check_clear("reset_clear");
        chk("post_clear_ready", 32'(in_ready), 32'd1);
        chk("post_clear_busy", 32'(busy), 32'd0);
        chk("post_clear_cursor", 32'({cursor_row, cursor_col}), 32'd0);

        // vector table
        foreach (vt[i]) begin
            log_q.delete();
            send_byte(vt[i].ch);
            wait_idle(c);
            chk($sformatf("vec%0d_nwr", i), 32'(log_q.size()), 32'(vt[i].nwr));
            if (vt[i].nwr > 0 && log_q.size() > 0) begin
                chk($sformatf("vec%0d_addr", i), 32'(log_q[0].addr), 32'(vt[i].addr));
                chk($sformatf("vec%0d_data", i), 32'(log_q[0].data), 32'(vt[i].data));
            end
            chk($sformatf("vec%0d_col", i), 32'(cursor_col), 32'(vt[i].col));
            chk($sformatf("vec%0d_row", i), 32'(cursor_row), 32'(vt[i].row));
        end

        // last column wrap with cycle-accurate latency
        repeat (5) begin send_byte(8'h0A); wait_idle(c); end
        repeat (63) begin send_byte(8'h2E); wait_idle(c); end
        chk("pre_wrap_cursor", 32'({cursor_row, cursor_col}), 32'({6'd5, 6'd63}));
        in_valid = 1'b1;
        in_data  = 8'h41;
        @(negedge clk);
        chk("wrap_accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("decode_busy_no_access", 32'({busy, mem_we, mem_re}), 32'b100);
        @(negedge clk);
        chk("wrap_put_we", 32'(mem_we), 32'd1);
        chk("wrap_put_addr", 32'(mem_addr), 32'h117F);
        chk("wrap_put_data", 32'(mem_wdata), 32'h41);
        @(negedge clk);
        chk("wrap_ready_again", 32'(in_ready), 32'd1);
        chk("wrap_cursor", 32'({cursor_row, cursor_col}), 32'({6'd6, 6'd0}));
        @(posedge clk);
        #1;
        log_q.delete();
        send_byte(8'h0D); wait_idle(c);
        send_byte(8'h0A); wait_idle(c);
        chk("crlf_no_writes", 32'(log_q.size()), 32'd0);
        chk("crlf_cursor", 32'({cursor_row, cursor_col}), 32'({6'd7, 6'd0}));

        // scroll from the bottom row with each row preloaded with its index
        send_byte(8'h0C); wait_idle(c);
        for (int i = 0; i < CELLS; i++) ram[i] = 8'(i / COLS);
        repeat (ROWS - 1) begin send_byte(8'h0A); wait_idle(c); end
        chk("bottom_row", 32'(cursor_row), 32'd36);
        log_q.delete();
        send_byte(8'h0A);
        wait_idle(c);
        chk("scroll_cycles", 32'(c), 32'(1 + 2 * KEEP + COLS));
        chk("scroll_access_count", 32'(log_q.size()), 32'(2 * KEEP + COLS));
        bad = 0;
        if (log_q.size() == 2 * KEEP + COLS) begin
            for (int i = 0; i < KEEP; i++) begin
                if (log_q[2*i].wr || log_q[2*i].addr != 15'(BASE + COLS + i)) bad++;
                if (!log_q[2*i+1].wr || log_q[2*i+1].addr != 15'(BASE + i) ||
                    log_q[2*i+1].data != 8'(i / COLS + 1)) bad++;
            end
            for (int k = 0; k < COLS; k++)
                if (!log_q[2*KEEP+k].wr || log_q[2*KEEP+k].addr != 15'(BASE + KEEP + k) ||
                    log_q[2*KEEP+k].data != 8'h20) bad++;
        end
        chk("scroll_sequence", 32'(bad), 32'd0);
        chk("scroll_row0", 32'(ram[0]), 32'd1);
        bad = 0;
        for (int i = 0; i < CELLS; i++)
            if (ram[i] != ((i < KEEP) ? 8'(i / COLS + 1) : 8'h20)) bad++;
        chk("scroll_ram", 32'(bad), 32'd0);
        chk("scroll_cursor", 32'({cursor_row, cursor_col}), 32'({6'd36, 6'd0}));

        // clear has priority over a pending byte
        log_q.delete();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h51;
        @(negedge clk);
        chk("clear_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        wait_idle(c);
        check_clear("clear_priority");
        chk("clear_cursor", 32'({cursor_row, cursor_col}), 32'd0);

        // reset in the middle of a scroll
        repeat (ROWS - 1) begin send_byte(8'h0A); wait_idle(c); end
        send_byte(8'h0A);
        repeat (100) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we_re", 32'({mem_we, mem_re}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_cursor", 32'({cursor_row, cursor_col}), 32'd0);
        log_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(c);
        chk("midrst_clear_cycles", 32'(c), 32'(CELLS));
        check_clear("midrst_clear");

        // random bytes with a stalling arbiter against the screen model
        gnt_rand = 1'b1;
        drive(8'h0C);
        repeat (34) drive(8'h0A);
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 78) b = 8'h08;
            else if (r < 83) b = 8'h0D;
            else if (r < 88) b = 8'h0A;
            else             b = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(8'h7F, 8'hFF)) : 8'h1B;
            drive(b);
        end
        gnt_rand = 1'b0;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] != scr[i]) bad++;
        chk("rand_ram_vs_model", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
